// File: rtl/cic_decim_mc.sv
// cic_decim_mc: multichannel CIC decimator with per-channel integrators and one shared time-multiplexed comb engine
module cic_decim_mc #(
    parameter int CH         = 4,
    parameter int ORDER      = 4,
    parameter int DIFF_DELAY = 1,
    parameter int RMAX       = 1024,
    parameter int RATE_W     = 16,
    parameter int OUT_W      = 32,
    localparam int ACC_W     = ORDER * $clog2(RMAX * DIFF_DELAY) + 2,
    localparam int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH-1:0]           din,
    input  logic                    din_valid,
    input  logic [RATE_W-1:0]       rate,
    input  logic                    rate_we,
    output logic signed [OUT_W-1:0] out,
    output logic [CHW-1:0]          out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);
    localparam int CW = $clog2(RMAX) + 1;
    localparam int SW = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam int WW = $clog2(ORDER + 1);

    typedef enum logic [1:0] {IDLE, COMB, OUT} state_t;

    state_t                  state;
    logic [CW-1:0]           r, cnt, r_new;
    logic                    tick;
    logic signed [ACC_W-1:0] last [CH];
    logic signed [ACC_W-1:0] snap [CH];
    logic signed [ACC_W-1:0] dly [CH][ORDER][DIFF_DELAY];
    logic signed [ACC_W-1:0] x, cur, y;
    logic signed [OUT_W-1:0] scaled;
    logic [CHW-1:0]          ch;
    logic [SW-1:0]           stage;
    logic [WW-1:0]           warm;

    assign r_new = (rate < RATE_W'(2)) ? CW'(2) : (32'(rate) > RMAX) ? CW'(RMAX) : CW'(rate);
    assign tick  = din_valid && !rate_we && cnt == r - CW'(1);

    // Integrator chains: each stage adds the freshly updated value of the stage before it,
    // so a tick snapshot sees the whole cascade including the current input sample.
    for (genvar c = 0; c < CH; c++) begin : chn
        for (genvar k = 0; k < ORDER; k++) begin : stg
            logic signed [ACC_W-1:0] acc, sum;
            if (k == 0) begin : g_in
                assign sum = acc + (din[c] ? ACC_W'(1) : '1);
            end else begin : g_up
                assign sum = acc + stg[k-1].sum;
            end
            // Wrapping accumulate on every PDM enable; flushed by reset or a rate load.
            always_ff @(posedge clk) begin
                if (rst || rate_we) acc <= '0;
                else if (din_valid) acc <= sum;
            end
        end
        assign last[c] = stg[ORDER-1].sum;
    end

    assign cur = (stage == '0) ? snap[ch] : x;
    assign y   = cur - dly[ch][stage][DIFF_DELAY-1];

    if (ACC_W <= OUT_W) begin : g_ext
        assign scaled = OUT_W'(y);
    end else begin : g_trunc
        assign scaled = y[ACC_W-1 -: OUT_W];
    end

    // Rate register and decimation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r   <= CW'(2);
            cnt <= '0;
        end else if (rate_we) begin
            r   <= r_new;
            cnt <= '0;
        end else if (din_valid) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    // Comb engine: one comb stage per cycle per channel, then hold the result until accepted.
    always_ff @(posedge clk) begin
        if (rst || rate_we) begin
            state     <= IDLE;
            ch        <= '0;
            stage     <= '0;
            x         <= '0;
            warm      <= WW'(ORDER);
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                snap[c] <= '0;
                for (int k = 0; k < ORDER; k++)
                    for (int i = 0; i < DIFF_DELAY; i++)
                        dly[c][k][i] <= '0;
            end
        end else begin
            if (tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (tick) begin
                    for (int c = 0; c < CH; c++) snap[c] <= last[c];
                    ch    <= '0;
                    stage <= '0;
                    state <= COMB;
                end
                COMB: begin
                    dly[ch][stage][0] <= cur;
                    for (int i = 1; i < DIFF_DELAY; i++) dly[ch][stage][i] <= dly[ch][stage][i-1];
                    x     <= y;
                    stage <= stage + 1'b1;
                    if (stage == SW'(ORDER - 1)) begin
                        stage <= '0;
                        if (warm == '0) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out       <= scaled;
                            out_ch    <= ch;
                        end else if (ch == CHW'(CH - 1)) begin
                            state <= IDLE;
                            warm  <= warm - 1'b1;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (ch == CHW'(CH - 1)) begin
                        state <= IDLE;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= COMB;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cic_decim_mc.sv
// tb_cic_decim_mc: directed checks of the multichannel CIC decimator (CH=2, ORDER=4, M=1, OUT_W=48)
module tb_cic_decim_mc;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         din = 2'b01;
    logic               din_valid = 1'b0;
    logic [15:0]        rate = '0;
    logic               rate_we = 1'b0;
    logic signed [47:0] out;
    logic [0:0]         out_ch;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               overrun;
    int                 checks = 0;
    int                 errors = 0;
    bit                 alt = 1'b0;
    longint             cv[$];
    int                 cc[$];

    always #5 clk = ~clk;

    cic_decim_mc #(
        .CH(2), .ORDER(4), .DIFF_DELAY(1), .RMAX(1024), .RATE_W(16), .OUT_W(48)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .rate(rate),
        .rate_we(rate_we), .out(out), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun)
    );

    // Record every accepted sample.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            cv.push_back(out);
            cc.push_back(int'(out_ch));
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] r);
        @(posedge clk); #1;
        rate = r;
        rate_we = 1'b1;
        @(posedge clk); #1;
        rate_we = 1'b0;
    endtask

    task automatic pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (alt) din[0] = ~din[0];
            din_valid = 1'b1;
            @(posedge clk); #1;
            din_valid = 1'b0;
            repeat (gap - 1) @(posedge clk);
        end
    endtask

    task automatic chk_dc(input string tag, input int n, input longint a);
        chk({tag, " count"}, cv.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < cv.size()) begin
                chk({tag, " ch"}, cc[i], i % 2);
                chk({tag, " val"}, cv[i], (i % 2) ? -a : a);
            end
        end
    endtask

    initial begin
        wait_cyc(3);
        chk("rst out_valid", out_valid, 0);
        chk("rst out", out, 0);
        chk("rst out_ch", out_ch, 0);
        chk("rst overrun", overrun, 0);
        rst = 1'b0;

        load(16'd3);
        cv.delete(); cc.delete();
        pulses(12, 16);
        wait_cyc(20);
        chk("warmup silent", cv.size(), 0);
        pulses(9, 16);
        wait_cyc(20);
        chk_dc("dc r3", 6, 81);
        chk("dc r3 overrun", overrun, 0);

        load(16'd2);
        din = 2'b11;
        alt = 1'b1;
        cv.delete(); cc.delete();
        pulses(16, 16);
        wait_cyc(20);
        alt = 1'b0;
        chk("alt count", cv.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < cv.size()) begin
                chk("alt ch", cc[i], i % 2);
                chk("alt val", cv[i], (i % 2) ? 16 : 0);
            end
        end

        din = 2'b01;
        load(16'd0);
        cv.delete(); cc.delete();
        pulses(10, 16);
        wait_cyc(20);
        chk_dc("rate0", 2, 16);
        load(16'd1);
        cv.delete(); cc.delete();
        pulses(10, 16);
        wait_cyc(20);
        chk_dc("rate1", 2, 16);

        load(16'd5000);
        cv.delete(); cc.delete();
        pulses(6144, 1);
        wait_cyc(20);
        chk_dc("rate5000 wrap", 4, 64'sd1099511627776);

        load(16'd3);
        cv.delete(); cc.delete();
        pulses(12, 16);
        out_ready = 1'b0;
        pulses(3, 16);
        wait_cyc(1);
        chk("bp valid", out_valid, 1);
        chk("bp out", out, 81);
        chk("bp ch", out_ch, 0);
        wait_cyc(10);
        chk("bp hold valid", out_valid, 1);
        chk("bp hold out", out, 81);
        chk("bp hold ch", out_ch, 0);
        pulses(3, 16);
        wait_cyc(1);
        chk("ovr set", overrun, 1);
        chk("ovr out", out, 81);
        chk("ovr ch", out_ch, 0);
        chk("ovr valid", out_valid, 1);
        chk("bp none lost", cv.size(), 0);
        out_ready = 1'b1;
        wait_cyc(20);
        chk_dc("bp deliver", 2, 81);
        pulses(6, 16);
        wait_cyc(5);
        chk("ovr sticky", overrun, 1);
        load(16'd3);
        chk("ovr cleared", overrun, 0);

        pulses(15, 16);
        pulses(2, 16);
        cv.delete(); cc.delete();
        @(posedge clk); #1;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        rate = 16'd4;
        rate_we = 1'b1;
        @(posedge clk); #1;
        rate_we = 1'b0;
        chk("flush valid", out_valid, 0);
        wait_cyc(20);
        chk("flush aborted", cv.size(), 0);
        pulses(16, 16);
        wait_cyc(20);
        chk("flush warmup", cv.size(), 0);
        pulses(8, 16);
        wait_cyc(20);
        chk_dc("flush r4", 4, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
